// File: rtl/vga_pkg.sv
// vga_pkg: shared field addresses, rectangle record and colour constants for the rectangle compositor
package vga_pkg;
  localparam logic [2:0] F_X0 = 3'd0;
  localparam logic [2:0] F_Y0 = 3'd1;
  localparam logic [2:0] F_X1 = 3'd2;
  localparam logic [2:0] F_Y1 = 3'd3;
  localparam logic [2:0] F_RGB = 3'd4;
  localparam logic [2:0] F_CTRL = 3'd5;
  // Internal coordinate width; COORD_W of the ports must not exceed it
  localparam int CW = 16;
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_RED = 12'hF00;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_BLUE = 12'h00F;
  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [11:0] rgb;
    logic en;
    logic [3:0] dx;
    logic [3:0] dy;
  } rect_t;
endpackage

// File: rtl/vga_rect_unit.sv
// vga_rect_unit: one rectangle - shadow/active registers, dirty flag, hit test, optional bounce motion
// Ports: clk, rst_n (async active-low); wr_en/wr_field/wr_data program the shadow copy;
// frame_start promotes shadow to active (or moves the rectangle); xpos/ypos in, hit/rgb out.
// Motion is built only when VGA_RECT_BOUNCE_EN is defined.
module vga_rect_unit
  import vga_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int H_VIS = 640,
  parameter int V_VIS = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_field,
  input  logic [COORD_W-1:0] wr_data,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic               hit,
  output logic [11:0]        rgb
);
  rect_t shd, act, nxt;
  logic dirty;
  logic [CW-1:0] d, x, y;
  assign d = CW'(wr_data);
  assign x = CW'(xpos);
  assign y = CW'(ypos);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd <= '0;
      act <= '0;
      dirty <= 1'b0;
    end else if (frame_start) begin
      act <= dirty ? shd : nxt;
      dirty <= 1'b0;
    end else if (wr_en && wr_field <= F_CTRL) begin
      dirty <= 1'b1;
      case (wr_field)
        F_X0: shd.x0 <= d;
        F_Y0: shd.y0 <= d;
        F_X1: shd.x1 <= d;
        F_Y1: shd.y1 <= d;
        F_RGB: shd.rgb <= d[11:0];
        default: {shd.dy, shd.dx, shd.en} <= d[8:0];
      endcase
    end
  end
  // Empty rectangles (x1<=x0 or y1<=y0) fail the half-open compare naturally
  assign hit = act.en && act.x0 <= x && x < act.x1 && act.y0 <= y && y < act.y1;
  assign rgb = act.rgb;
`ifdef VGA_RECT_BOUNCE_EN
  // Two extra bits so a step below zero stays negative and can be detected
  logic signed [CW+1:0] dxs, dys, nx0, nx1, ny0, ny1;
  logic bx, by;
  always_comb begin
    dxs = (CW+2)'($signed(act.dx));
    dys = (CW+2)'($signed(act.dy));
    nx0 = $signed({2'b00, act.x0}) + dxs;
    nx1 = $signed({2'b00, act.x1}) + dxs;
    ny0 = $signed({2'b00, act.y0}) + dys;
    ny1 = $signed({2'b00, act.y1}) + dys;
    bx = nx0 < 0 || nx1 > H_VIS;
    by = ny0 < 0 || ny1 > V_VIS;
    nxt = act;
    if (act.en) begin
      nxt.dx = bx ? -act.dx : act.dx;
      nxt.x0 = bx ? act.x0 : nx0[CW-1:0];
      nxt.x1 = bx ? act.x1 : nx1[CW-1:0];
      nxt.dy = by ? -act.dy : act.dy;
      nxt.y0 = by ? act.y0 : ny0[CW-1:0];
      nxt.y1 = by ? act.y1 : ny1[CW-1:0];
    end
  end
`else
  logic [31:0] unused_vis;
  assign unused_vis = H_VIS ^ V_VIS;
  assign nxt = act;
`endif
endmodule

// File: rtl/vga_rect_overlay.sv
// vga_rect_overlay: N programmable rectangles composited over a background for the VGA pixel stream
// Ports: CLK, RST (async active-low), P_CLK pixel enable, XPOS/YPOS/DISP_ACTIVE from the sync
// generator, FRAME_START commits pending writes, WR_EN/WR_ADDR/WR_DATA/WR_READY write port,
// Ro/Go/Bo/PIX_VALID registered pixel outputs (one pixel of latency).
// Optional per-frame bounce motion: define VGA_RECT_BOUNCE_EN.
module vga_rect_overlay
  import vga_pkg::*;
#(
  parameter int N_RECT = 4,
  parameter int COORD_W = 12,
  parameter int H_VIS = 640,
  parameter int V_VIS = 480,
  parameter logic [11:0] BG_RGB = RGB_BLACK
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      P_CLK,
  input  logic [COORD_W-1:0]        XPOS,
  input  logic [COORD_W-1:0]        YPOS,
  input  logic                      DISP_ACTIVE,
  input  logic                      FRAME_START,
  input  logic                      WR_EN,
  input  logic [$clog2(N_RECT)+2:0] WR_ADDR,
  input  logic [COORD_W-1:0]        WR_DATA,
  output logic                      WR_READY,
  output logic [3:0]                Ro,
  output logic [3:0]                Go,
  output logic [3:0]                Bo,
  output logic                      PIX_VALID
);
  localparam int AW = $clog2(N_RECT) + 3;
  logic [N_RECT-1:0] hit;
  logic [11:0] rgb [N_RECT];
  logic [11:0] pix;
  logic wr_acc;
  // Holding writes off during FRAME_START keeps the shadow-to-active copy atomic
  assign WR_READY = ~FRAME_START;
  assign wr_acc = WR_EN & WR_READY;
  for (genvar i = 0; i < N_RECT; i++) begin : g_rect
    vga_rect_unit #(.COORD_W(COORD_W), .H_VIS(H_VIS), .V_VIS(V_VIS)) u_rect (
      .clk(CLK),
      .rst_n(RST),
      .wr_en(wr_acc && (WR_ADDR >> 3) == AW'(i)),
      .wr_field(WR_ADDR[2:0]),
      .wr_data(WR_DATA),
      .frame_start(FRAME_START),
      .xpos(XPOS),
      .ypos(YPOS),
      .hit(hit[i]),
      .rgb(rgb[i])
    );
  end
  // Scan from the top index down so the lowest-index hit is the last to assign
  always_comb begin
    pix = BG_RGB;
    for (int i = N_RECT - 1; i >= 0; i--) pix = hit[i] ? rgb[i] : pix;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {Ro, Go, Bo} <= RGB_BLACK;
      PIX_VALID <= 1'b0;
    end else if (P_CLK) begin
      {Ro, Go, Bo} <= DISP_ACTIVE ? pix : RGB_BLACK;
      PIX_VALID <= DISP_ACTIVE;
    end
  end
endmodule

// File: doc/vga_rect_overlay.md
# vga_rect_overlay

Parametrised rectangle compositor for the VGA pipeline: holds N programmable rectangles (position, size, colour, priority by index) and produces 4-bit-per-channel RGB for the current pixel from the sync generator's XPOS/YPOS. It sits between `VGA_Sync_Calc` and the DAC pins and replaces the fixed-pattern colour logic in the top level. Rectangles are programmed through a write port into shadow registers that become visible only at frame start, so there is no tearing. Optional per-frame motion with edge bounce is also supported.

## Interface
- `N_RECT`, 4: number of rectangles; 1..16.
- `COORD_W`, 12: width of XPOS/YPOS and of all coordinates.
- `H_VIS`, 640: visible width; used for bounce limits.
- `V_VIS`, 480: visible height; used for bounce limits.
- `BG_RGB`, 12'h000: background colour {R,G,B} inside the active area.
- `CLK  in  1`: system clock.
- `RST  in  1`: reset; asynchronous, active-low.
- `P_CLK  in  1`: pixel enable from `VGA_Freq_Div`; one CLK cycle wide.
- `XPOS, YPOS  in  COORD_W`: current pixel coordinates.
- `DISP_ACTIVE  in  1`: high when XPOS/YPOS are in the visible area.
- `FRAME_START  in  1`: one-CLK pulse at the start of vertical blanking.
- `WR_EN  in  1`: write request.
- `WR_ADDR  in  $clog2(N_RECT)+3`: {rect index, field[2:0]}.
- `WR_DATA  in  COORD_W`: write data.
- `WR_READY  out  1`: a write is accepted when WR_EN and WR_READY are both high.
- `Ro, Go, Bo  out  4`: registered colour outputs.
- `PIX_VALID  out  1`: registered copy of DISP_ACTIVE, aligned with the RGB outputs.

## Operation
- Field map:
  - 0: X0
  - 1: Y0
  - 2: X1
  - 3: Y1
  - 4: colour[11:0] {R,G,B}
  - 5: ctrl: bit0 = enable, bits[4:1] = DX (signed), bits[8:5] = DY (signed)
  - 6–7: writes ignored
- An out-of-range rect index is ignored and the write is still accepted.
- Writes go to shadow registers and set the per-rect `dirty` bit.
- Hit test: X0 ≤ XPOS < X1 and Y0 ≤ YPOS < Y1, unsigned compare. A rectangle with X1 ≤ X0 or Y1 ≤ Y0 never hits.
- Compositing: the lowest-index enabled rectangle that hits wins. If none hits, the output is BG_RGB. When DISP_ACTIVE is low, the output is 0.
- On FRAME_START, for each rect:
  - if dirty: copy shadow to active and clear dirty;
  - otherwise apply motion (see Configuration).
- A write in the same cycle as FRAME_START: WR_READY is low that cycle, so the write is held off and lands after the copy.

## Timing
- The pixel path updates only on P_CLK. RGB and PIX_VALID appear on the P_CLK cycle after XPOS/YPOS are presented (latency 1 pixel).
- WR_READY is high at all times except the FRAME_START cycle. An accepted write is visible on screen from the next FRAME_START.
- Reset values:
  - Ro/Go/Bo = 0, PIX_VALID = 0, WR_READY = 1.
  - All shadow and active registers = 0, all rectangles disabled, dirty = 0.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). After release, the first pixel output is BG/0.

## Configuration
- `VGA_RECT_BOUNCE_EN` defined:
  - At FRAME_START each non-dirty, enabled rect moves by (DX, DY).
  - If X0+DX < 0 or X1+DX > H_VIS, DX is negated in the active register and X does not move that frame. Y is handled the same way against V_VIS.
  - DX = DY = 0 means static.
- Not defined: DX/DY bits are stored but ignored, active positions change only on dirty copy, and no adder or compare logic is built.

## Structure
- Package `vga_pkg`:
  - field address constants;
  - `rect_t` typedef {x0, y0, x1, y1, rgb, en, dx, dy};
  - default colour constants.
- Sub-module `vga_rect_unit`: one per rectangle via generate. Holds the shadow/active register, dirty bit, hit comparator and bounce logic, and outputs a `hit` flag and `rgb`.
- The top handles the write decode, the priority encoder and the output register.

## Test plan
- Reset, then DISP_ACTIVE = 1, no writes: RGB = 0 after reset and BG_RGB one pixel later. PIX_VALID follows DISP_ACTIVE with 1-pixel delay.
- Program rect0 = (120,40)-(280,200), colour 12'h0F0, enable, then pulse FRAME_START:
  - XPOS=120, YPOS=40 → Go = F;
  - XPOS=280 → BG (right edge exclusive).
- Overlap: rect0 green and rect1 red, both covering (250,150): output green. Disable rect0 and pulse FRAME_START: output red.
- Write to X0 in the same cycle as FRAME_START: WR_READY is low. The write is accepted on the next cycle and has no visual effect until the following FRAME_START.
- With `VGA_RECT_BOUNCE_EN`: rect X0=630, X1=638, DX=+4. After 1 frame X0 is unchanged and DX becomes −4; after 2 frames X0 = 626.
- Assert RST mid-line with rects active: outputs go to 0 asynchronously. After release all rects are disabled and the output is BG.
